uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequencer for the UART byte receiver. Generates the 8x oversampling
//  sample_tick, assembles NBYTES received bytes into one frame, rejects
//  frames on parity error or inter-byte timeout, and hands completed frames
//  downstream on a valid/ready handshake. Keeps sticky status and counters.
// PARAMETERS
//  SAMPLE_DIV     54   clk cycles per sample_tick (50 MHz / (115200*8))
//  NBYTES         8    bytes per frame, >= 2
//  TIMEOUT_TICKS  160  sample ticks of silence that abort a partial frame
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous active-low reset
//  rx_en         in   1         receive enable
//  sample_tick   out  1         one-cycle strobe to the receiver, every SAMPLE_DIV clk
//  byte_valid    in   1         one-cycle pulse: receiver finished a byte
//  byte_data     in   8         received byte, valid with byte_valid
//  parity_ok     in   1         parity result for byte_data; tie 1 if parity disabled
//  frame_data    out  8*NBYTES  assembled frame; first byte received in [7:0]
//  frame_valid   out  1         frame_data holds a complete, checked frame
//  frame_ready   in   1         downstream accepts frame when high with frame_valid
//  busy          out  1         state != IDLE
//  clr_status    in   1         one-cycle clear of sticky flags and counters
//  overrun       out  1         sticky: byte dropped while frame unconsumed
//  timeout       out  1         sticky: partial frame aborted on silence
//  parity_err    out  1         sticky: frame discarded on parity error
//  ok_cnt        out  16        frames delivered, saturating
//  err_cnt       out  8         error events (overrun/timeout/parity), saturating
// BEHAVIOUR
//  Reset: all outputs 0, div_cnt=0, gap_cnt=0, byte index=0, state IDLE.
//  Tick: div_cnt counts 0..SAMPLE_DIV-1 and wraps; sample_tick=1 in the cycle
//   div_cnt==SAMPLE_DIV-1. rx_en=0: div_cnt held 0, no ticks; COLLECT/FLUSH
//   go to IDLE next cycle, partial frame discarded silently; HOLD unaffected.
//  gap_cnt: cleared on byte_valid, else +1 per sample_tick; saturates at
//   TIMEOUT_TICKS; cleared on entry to IDLE.
//  IDLE: byte_valid&parity_ok -> byte at index 0, idx=1, COLLECT.
//   byte_valid&!parity_ok -> parity_err=1, err_cnt+1, FLUSH.
//  COLLECT: byte_valid&parity_ok -> store at byte idx, idx+1; if idx was
//   NBYTES-1 -> HOLD, frame_valid=1 next cycle, ok_cnt+1.
//   byte_valid&!parity_ok -> parity_err, err_cnt+1, FLUSH.
//   gap_cnt==TIMEOUT_TICKS (no byte_valid that cycle) -> timeout, err_cnt+1, IDLE.
//  FLUSH: all bytes dropped; gap_cnt==TIMEOUT_TICKS -> IDLE (resync on silence).
//  HOLD: frame_valid=1, frame_data stable. frame_ready -> frame_valid=0 next
//   cycle. frame_ready&byte_valid&parity_ok same cycle: byte becomes index 0,
//   COLLECT; with !parity_ok: parity_err, FLUSH; else ready -> IDLE.
//   byte_valid without frame_ready: byte dropped, overrun=1, err_cnt+1, stay HOLD.
//  frame_data only written in IDLE/COLLECT stores; unchanged otherwise.
//  Latency: frame_valid rises 1 clk after the last byte_valid.
//  Counters saturate (ok 16'hFFFF, err 8'hFF). clr_status clears flags and
//   counters; an event in the same cycle wins (flag=1, counter=1).
//  Two error events in one cycle count once.
// TESTING
//  Reset, rx_en=1, SAMPLE_DIV=54 -> sample_tick period exactly 54 clk, 1 clk wide.
//  Bytes 01..08 all parity_ok -> frame_data=64'h0807060504030201,
//   frame_valid 1 clk after 8th byte, ok_cnt=1; frame_ready -> valid drops.
//  3 bytes then 160 ticks silence -> timeout=1, err_cnt=1, IDLE, no frame_valid;
//   next 8 bytes AA.. form a clean frame.
//  Byte 3 with parity_ok=0 -> parity_err=1, bytes 4..8 dropped, IDLE after
//   160 silent ticks, ok_cnt unchanged.
//  Frame held, frame_ready=0, 2 more bytes -> overrun=1, err_cnt=2, frame_data
//   unchanged; byte with frame_ready same cycle -> lands in [7:0], COLLECT.
//  clr_status with simultaneous overrun -> overrun=1, err_cnt=1; assert rst_n
//   low mid-frame -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Sequencer for the UART byte receiver. It produces the oversampling strobe
// for the receiver, gathers NBYTES received bytes into one frame, throws a
// frame away on a parity error or when the line goes quiet mid-frame, and
// offers each completed frame downstream on a valid/ready handshake. Sticky
// error flags and saturating counters summarise what happened since the
// last clr_status.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_en           receive enable; low stops the strobe and drops partial
//                   frames (a held frame is kept)
//   sample_tick     one-cycle strobe every SAMPLE_DIV clocks while enabled
//   byte_valid      one-cycle pulse from the receiver with a new byte
//   byte_data       received byte, qualified by byte_valid
//   parity_ok       parity result for byte_data
//   frame_data      assembled frame, first received byte in [7:0]
//   frame_valid     frame_data holds a complete checked frame
//   frame_ready     downstream takes the frame when high with frame_valid
//   busy            controller is not idle
//   clr_status      one-cycle clear of sticky flags and counters
//   overrun         sticky: byte dropped while a frame was waiting
//   timeout         sticky: partial frame abandoned on line silence
//   parity_err      sticky: frame discarded on a parity error
//   ok_cnt          frames delivered, saturating
//   err_cnt         error events, saturating (one per cycle at most)
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int SAMPLE_DIV    = 54,
    parameter int NBYTES        = 8,
    parameter int TIMEOUT_TICKS = 160
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_en,
    output logic                  sample_tick,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  parity_ok,
    output logic [8*NBYTES-1:0]   frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  busy,
    input  logic                  clr_status,
    output logic                  overrun,
    output logic                  timeout,
    output logic                  parity_err,
    output logic [15:0]           ok_cnt,
    output logic [7:0]            err_cnt
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int GAP_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int IDX_W = $clog2(NBYTES);

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_TICKS);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Delivered-frame counter update: a clear restarts from the event of
    // the same cycle, otherwise count up and stick at all-ones.
    function automatic logic [15:0] ok_cnt_next(input logic [15:0] cnt,
                                                input logic        ev,
                                                input logic        clr);
        logic [15:0] res;
        if (clr) begin
            res = {15'd0, ev};
        end else if (ev && (cnt != 16'hFFFF)) begin
            res = cnt + 16'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Error counter update, same rules as the frame counter.
    function automatic logic [7:0] err_cnt_next(input logic [7:0] cnt,
                                                input logic       ev,
                                                input logic       clr);
        logic [7:0] res;
        if (clr) begin
            res = {7'd0, ev};
        end else if (ev && (cnt != 8'hFF)) begin
            res = cnt + 8'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic [DIV_W-1:0]     div_r;
    logic [DIV_W-1:0]     div_nxt_s;
    logic [GAP_W-1:0]     gap_r;
    logic                 sample_tick_r;
    logic [8*NBYTES-1:0]  frame_data_r;
    logic                 frame_valid_r;
    logic                 busy_r;
    logic                 overrun_r;
    logic                 timeout_r;
    logic                 parity_err_r;
    logic [15:0]          ok_cnt_r;
    logic [7:0]           err_cnt_r;

    logic                 byte_good_s;
    logic                 byte_bad_s;
    logic                 store_s;
    logic [IDX_W-1:0]     store_idx_s;
    logic                 deliver_s;
    logic                 parity_ev_s;
    logic                 timeout_ev_s;
    logic                 overrun_ev_s;
    logic                 err_ev_s;
    logic                 enter_idle_s;

    assign byte_good_s  = byte_valid & parity_ok;
    assign byte_bad_s   = byte_valid & ~parity_ok;
    assign err_ev_s     = parity_ev_s | timeout_ev_s | overrun_ev_s;
    assign enter_idle_s = (state_nxt_s == ST_IDLE) && (state_r != ST_IDLE);

    // Divider next value: parked at zero while disabled, wraps at the end.
    always_comb begin
        div_nxt_s = DIV_ZERO;
        if (!rx_en) begin
            div_nxt_s = DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_nxt_s = DIV_ZERO;
        end else begin
            div_nxt_s = div_r + DIV_ONE;
        end
    end

    // Divider register; the strobe is registered so it is high exactly in
    // the cycle the divider sits on its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r         <= DIV_ZERO;
            sample_tick_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            sample_tick_r <= rx_en && (div_nxt_s == DIV_LAST);
        end
    end

    // Line-silence counter in sample ticks, reset by any byte or on the
    // way back to idle, stuck at the timeout value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_r <= GAP_ZERO;
        end else if (enter_idle_s || byte_valid) begin
            gap_r <= GAP_ZERO;
        end else if (sample_tick_r && (gap_r != GAP_MAX)) begin
            gap_r <= gap_r + GAP_ONE;
        end else begin
            gap_r <= gap_r;
        end
    end

    // Sequencer decode: next state, byte store and the events of this cycle.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        store_s      = 1'b0;
        store_idx_s  = IDX_ZERO;
        deliver_s    = 1'b0;
        parity_ev_s  = 1'b0;
        timeout_ev_s = 1'b0;
        overrun_ev_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_en && byte_good_s) begin
                    store_s     = 1'b1;
                    store_idx_s = IDX_ZERO;
                    idx_nxt_s   = IDX_ONE;
                    state_nxt_s = ST_COLLECT;
                end else if (rx_en && byte_bad_s) begin
                    parity_ev_s = 1'b1;
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (!rx_en) begin
                    // Receiver switched off: the partial frame just vanishes.
                    idx_nxt_s   = IDX_ZERO;
                    state_nxt_s = ST_IDLE;
                end else if (byte_good_s) begin
                    store_s     = 1'b1;
                    store_idx_s = idx_r;
                    if (idx_r == IDX_LAST) begin
                        deliver_s   = 1'b1;
                        idx_nxt_s   = IDX_ZERO;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                        state_nxt_s = ST_COLLECT;
                    end
                end else if (byte_bad_s) begin
                    parity_ev_s = 1'b1;
                    idx_nxt_s   = IDX_ZERO;
                    state_nxt_s = ST_FLUSH;
                end else if (gap_r == GAP_MAX) begin
                    timeout_ev_s = 1'b1;
                    idx_nxt_s    = IDX_ZERO;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_FLUSH: begin
                // Drop everything until the line has been quiet long enough
                // to be sure the next byte starts a fresh frame.
                if (!rx_en || (gap_r == GAP_MAX)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    // A byte arriving with the handshake starts the next frame.
                    if (byte_good_s) begin
                        store_s     = 1'b1;
                        store_idx_s = IDX_ZERO;
                        idx_nxt_s   = IDX_ONE;
                        state_nxt_s = ST_COLLECT;
                    end else if (byte_bad_s) begin
                        parity_ev_s = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (byte_valid) begin
                    overrun_ev_s = 1'b1;
                    state_nxt_s  = ST_HOLD;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                idx_nxt_s   = IDX_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with the frame buffer and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= IDX_ZERO;
            frame_data_r  <= {(8*NBYTES){1'b0}};
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            frame_valid_r <= (state_nxt_s == ST_HOLD);
            busy_r        <= (state_nxt_s != ST_IDLE);
            if (store_s) begin
                frame_data_r[{store_idx_s, 3'b000} +: 8] <= byte_data;
            end else begin
                frame_data_r <= frame_data_r;
            end
        end
    end

    // Sticky flags and counters; an event in the clearing cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
            parity_err_r <= 1'b0;
            ok_cnt_r     <= 16'd0;
            err_cnt_r    <= 8'd0;
        end else begin
            if (clr_status) begin
                overrun_r    <= overrun_ev_s;
                timeout_r    <= timeout_ev_s;
                parity_err_r <= parity_ev_s;
            end else begin
                overrun_r    <= overrun_r | overrun_ev_s;
                timeout_r    <= timeout_r | timeout_ev_s;
                parity_err_r <= parity_err_r | parity_ev_s;
            end
            ok_cnt_r  <= ok_cnt_next(ok_cnt_r, deliver_s, clr_status);
            err_cnt_r <= err_cnt_next(err_cnt_r, err_ev_s, clr_status);
        end
    end

    assign sample_tick = sample_tick_r;
    assign frame_data  = frame_data_r;
    assign frame_valid = frame_valid_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout     = timeout_r;
    assign parity_err  = parity_err_r;
    assign ok_cnt      = ok_cnt_r;
    assign err_cnt     = err_cnt_r;

endmodule
